adc_chan_averager: RTL and testbench

Per-channel boxcar decimator sitting directly downstream of the AD7608 serial read controller. It captures each channel's word when that channel's one-hot valid bit fires and accumulates 2^k samples per channel. It then emits the arithmetic mean as a tagged (channel, value) stream to the PID core through a 4-entry valid/ready FIFO. Two channels complete on the same cycle, one per serial port, so the FIFO serialises them A-side first.

---
 rtl/adc_chan_averager_if.sv | 44 ++++
 rtl/adc_chan_averager.sv | 182 ++++++++++++++++++
 tb/tb_adc_chan_averager.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_chan_averager_if.sv
// Bundle of the sample inputs and the averaged output stream of
// adc_chan_averager.
//   master : upstream ADC controller plus downstream PID consumer. It
//            drives the valid, data, exponent, update and ready inputs.
//   slave  : the averager. It drives the FIFO head, its valid and the
//            sticky overflow flag.
// Signals:
//   data_valid_in  one-hot-per-port sample strobes (N_CHAN bits)
//   data_a_in      port A sample word (signed W_IN)
//   data_b_in      port B sample word (signed W_IN)
//   avg_log2_in    requested averaging exponent
//   update_in      pulse that loads avg_log2_in
//   ready_in       consumer accepts the FIFO head
//   data_valid_out FIFO non-empty
//   data_out       averaged value at the FIFO head
//   chan_out       channel tag at the FIFO head
//   overflow_out   sticky flag, set when a result was dropped
interface adc_chan_averager_if #(
  parameter int W_IN   = 18,
  parameter int N_CHAN = 8
);
  localparam int W_CHAN = $clog2(N_CHAN);

  logic [N_CHAN-1:0]      data_valid_in;
  logic signed [W_IN-1:0] data_a_in;
  logic signed [W_IN-1:0] data_b_in;
  logic [3:0]             avg_log2_in;
  logic                   update_in;
  logic                   ready_in;
  logic                   data_valid_out;
  logic signed [W_IN-1:0] data_out;
  logic [W_CHAN-1:0]      chan_out;
  logic                   overflow_out;

  modport master (
    output data_valid_in, data_a_in, data_b_in, avg_log2_in, update_in, ready_in,
    input  data_valid_out, data_out, chan_out, overflow_out
  );

  modport slave (
    input  data_valid_in, data_a_in, data_b_in, avg_log2_in, update_in, ready_in,
    output data_valid_out, data_out, chan_out, overflow_out
  );
endinterface

// File: rtl/adc_chan_averager.sv
// Per-channel boxcar decimator for the dual-port AD7608 read path. Each
// channel accumulates 2^k samples. The floored mean is then pushed, tagged
// with its channel, into a 4-entry first-word-fall-through FIFO. Up to two
// channels can complete per cycle, one per port, and the A side is queued
// first.
// Ports:
//   clk_in    ADC serial clock (single domain)
//   reset_in  synchronous active-high reset
//   bus       adc_chan_averager_if.slave (sample inputs, averaged output stream)
module adc_chan_averager #(
  parameter int W_IN     = 18,
  parameter int N_CHAN   = 8,
  parameter int MAX_LOG2 = 4
) (
  input logic               clk_in,
  input logic               reset_in,
  adc_chan_averager_if.slave bus
);
  localparam int W_CHAN = $clog2(N_CHAN);
  localparam int W_ACC  = W_IN + MAX_LOG2;
  localparam int W_CNT  = MAX_LOG2 + 1;
  localparam int W_K    = $clog2(MAX_LOG2 + 1);
  localparam int HALF   = N_CHAN / 2;
  localparam int W_ENT  = W_CHAN + W_IN;
  localparam logic [3:0] K_MAX = 4'(MAX_LOG2);

  // Arithmetic shift floors toward -inf. The mean always lies within the
  // input range, so dropping the top bits loses nothing.
  function automatic logic signed [W_IN-1:0] floor_mean(
    input logic signed [W_ACC-1:0] sum,
    input logic [W_K-1:0]          shift
  );
    logic signed [W_ACC-1:0] q;
    q = sum >>> shift;
    return q[W_IN-1:0];
  endfunction

  function automatic logic signed [W_ACC-1:0] sext(input logic signed [W_IN-1:0] s);
    return {{MAX_LOG2{s[W_IN-1]}}, s};
  endfunction

  logic [W_K-1:0]          k;
  logic signed [W_ACC-1:0] acc [N_CHAN];
  logic [W_CNT-1:0]        cnt [N_CHAN];
  logic [W_CNT-1:0]        target;

  logic [N_CHAN-1:0]       take;
  logic [N_CHAN-1:0]       done;
  logic signed [W_ACC-1:0] sum  [N_CHAN];
  logic signed [W_IN-1:0]  mean [N_CHAN];

  logic                    push_a, push_b;
  logic [W_CHAN-1:0]       chan_a, chan_b;
  logic signed [W_IN-1:0]  res_a, res_b;

  assign target = W_CNT'(1) << k;
  // Samples arriving together with an exponent update are discarded.
  assign take   = bus.data_valid_in & {N_CHAN{~bus.update_in}};

  always_comb begin
    for (int j = 0; j < N_CHAN; j++) begin
      sum[j]  = acc[j] + sext((j < HALF) ? bus.data_a_in : bus.data_b_in);
      mean[j] = floor_mean(sum[j], k);
      done[j] = take[j] && ((cnt[j] + W_CNT'(1)) == target);
    end
  end

  // Lowest completing index per port wins. A single strobe per port is the
  // legal case; this only keeps illegal upstream bursts well defined.
  always_comb begin
    push_a = 1'b0;
    chan_a = '0;
    res_a  = '0;
    push_b = 1'b0;
    chan_b = '0;
    res_b  = '0;
    for (int j = HALF - 1; j >= 0; j--) begin
      if (done[j]) begin
        push_a = 1'b1;
        chan_a = W_CHAN'(j);
        res_a  = mean[j];
      end
    end
    for (int j = N_CHAN - 1; j >= HALF; j--) begin
      if (done[j]) begin
        push_b = 1'b1;
        chan_b = W_CHAN'(j);
        res_b  = mean[j];
      end
    end
  end

  // ---- accumulate stage: exponent, per-channel sums and counts ----
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      k <= '0;
      for (int j = 0; j < N_CHAN; j++) begin
        acc[j] <= '0;
        cnt[j] <= '0;
      end
    end else if (bus.update_in) begin
      k <= (bus.avg_log2_in > K_MAX) ? W_K'(MAX_LOG2) : bus.avg_log2_in[W_K-1:0];
      for (int j = 0; j < N_CHAN; j++) begin
        acc[j] <= '0;
        cnt[j] <= '0;
      end
    end else begin
      for (int j = 0; j < N_CHAN; j++) begin
        if (take[j]) begin
          if (done[j]) begin
            acc[j] <= '0;
            cnt[j] <= '0;
          end else begin
            acc[j] <= sum[j];
            cnt[j] <= cnt[j] + W_CNT'(1);
          end
        end
      end
    end
  end

  logic [W_ENT-1:0] mem [4];
  logic [1:0]       rd_ptr, wr_ptr;
  logic [2:0]       count;
  logic             overflow;
  logic             pop;
  logic [2:0]       free;
  logic             wr0_en, wr1_en, drop;
  logic [W_ENT-1:0] wr0_data, wr1_data;
  logic [W_ENT-1:0] head;

  // A same-cycle pop frees its slot for this cycle's pushes. When space is
  // short, the B-side result is the one given up first.
  always_comb begin
    pop      = (count != 3'd0) && bus.ready_in;
    free     = 3'd4 - count + {2'b00, pop};
    wr0_en   = 1'b0;
    wr1_en   = 1'b0;
    drop     = 1'b0;
    wr0_data = {chan_a, res_a};
    wr1_data = {chan_b, res_b};
    if (push_a && push_b) begin
      wr0_en = (free >= 3'd1);
      wr1_en = (free >= 3'd2);
      drop   = (free < 3'd2);
    end else if (push_a) begin
      wr0_en = (free != 3'd0);
      drop   = (free == 3'd0);
    end else if (push_b) begin
      wr0_en   = (free != 3'd0);
      wr0_data = {chan_b, res_b};
      drop     = (free == 3'd0);
    end
  end

  // ---- FIFO stage: pointers, occupancy, sticky overflow ----
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      wr_ptr <= wr_ptr + {1'b0, wr0_en} + {1'b0, wr1_en};
      count  <= count - {2'b00, pop} + {2'b00, wr0_en} + {2'b00, wr1_en};
      if (bus.update_in) overflow <= 1'b0;
      else if (drop)     overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (wr0_en) mem[wr_ptr] <= wr0_data;
    if (wr1_en) mem[wr_ptr + 2'd1] <= wr1_data;
  end

  assign head               = mem[rd_ptr];
  assign bus.data_valid_out = (count != 3'd0);
  assign bus.data_out       = (count != 3'd0) ? head[W_IN-1:0] : '0;
  assign bus.chan_out       = (count != 3'd0) ? head[W_ENT-1:W_IN] : '0;
  assign bus.overflow_out   = overflow;
endmodule

// File: tb/tb_adc_chan_averager.sv
module tb_adc_chan_averager;
  localparam int W_IN     = 18;
  localparam int N_CHAN   = 8;
  localparam int MAX_LOG2 = 4;
  localparam int HALF     = N_CHAN / 2;

  logic clk_in = 1'b0;
  logic reset_in;
  always #5 clk_in = ~clk_in;

  adc_chan_averager_if #(.W_IN(W_IN), .N_CHAN(N_CHAN)) bus ();

  adc_chan_averager #(.W_IN(W_IN), .N_CHAN(N_CHAN), .MAX_LOG2(MAX_LOG2)) dut (
    .clk_in  (clk_in),
    .reset_in(reset_in),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: sample lists reduced to running sums, result queue.
  typedef struct {
    int chan;
    int data;
  } ent_t;

  ent_t    q[$];
  int      k_m = 0;
  longint  sum_m[N_CHAN];
  int      n_m[N_CHAN];
  bit      ovf_m = 1'b0;

  function automatic int floor_div(input longint s, input longint n);
    longint r;
    r = s / n;
    if ((s % n) != 0 && s < 0) r = r - 1;
    return int'(r);
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  function automatic void model_step();
    ent_t pend[$];
    ent_t e;
    bit   pop;
    int   s;
    if (reset_in) begin
      q.delete();
      ovf_m = 1'b0;
      k_m   = 0;
      for (int j = 0; j < N_CHAN; j++) begin
        sum_m[j] = 0;
        n_m[j]   = 0;
      end
      return;
    end
    pop = (q.size() != 0) && bus.ready_in;
    if (bus.update_in) begin
      k_m   = (int'(bus.avg_log2_in) > MAX_LOG2) ? MAX_LOG2 : int'(bus.avg_log2_in);
      ovf_m = 1'b0;
      for (int j = 0; j < N_CHAN; j++) begin
        sum_m[j] = 0;
        n_m[j]   = 0;
      end
    end else begin
      for (int j = 0; j < N_CHAN; j++) begin
        if (bus.data_valid_in[j]) begin
          s = (j < HALF) ? int'(bus.data_a_in) : int'(bus.data_b_in);
          sum_m[j] += s;
          n_m[j]++;
          if (n_m[j] == (1 << k_m)) begin
            e.chan = j;
            e.data = floor_div(sum_m[j], longint'(1) << k_m);
            pend.push_back(e);
            sum_m[j] = 0;
            n_m[j]   = 0;
          end
        end
      end
    end
    if (pop) void'(q.pop_front());
    foreach (pend[i]) begin
      if (q.size() < 4) q.push_back(pend[i]);
      else ovf_m = 1'b1;
    end
  endfunction

  task automatic step();
    model_step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic update(input int e);
    bus.avg_log2_in = 4'(e);
    bus.update_in   = 1'b1;
    step();
    bus.update_in   = 1'b0;
  endtask

  // One upstream event: optional A channel va, optional B channel vb (-1 = none).
  task automatic sample_ev(input int va, input int vb, input int a, input int b);
    logic [N_CHAN-1:0] v;
    v = '0;
    if (va >= 0) v[va] = 1'b1;
    if (vb >= 0) v[vb] = 1'b1;
    bus.data_valid_in = v;
    bus.data_a_in     = W_IN'(a);
    bus.data_b_in     = W_IN'(b);
    step();
    bus.data_valid_in = '0;
  endtask

  task automatic test_reset();
    reset_in = 1'b1;
    step();
    step();
    checks++;
    if (bus.data_valid_out !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid got=%0b exp=0", bus.data_valid_out);
    end
    checks++;
    if (bus.data_out !== 0 || bus.chan_out !== 0) begin
      failures++;
      $display("FAIL reset_head got chan=%0d data=%0d exp chan=0 data=0", bus.chan_out, bus.data_out);
    end
    checks++;
    if (bus.overflow_out !== 1'b0) begin
      failures++;
      $display("FAIL reset_ovf got=%0b exp=0", bus.overflow_out);
    end
    reset_in = 1'b0;
  endtask

  task automatic test_passthrough();
    bus.ready_in = 1'b1;
    update(0);
    sample_ev(0, 4, 100, -5);
    checks++;
    if (bus.data_valid_out !== 1'b1 || bus.chan_out !== 0 || bus.data_out !== 100) begin
      failures++;
      $display("FAIL pt_first got v=%0b chan=%0d data=%0d exp v=1 chan=0 data=100",
               bus.data_valid_out, bus.chan_out, bus.data_out);
    end
    step();
    checks++;
    if (bus.data_valid_out !== 1'b1 || bus.chan_out !== 4 || bus.data_out !== -5) begin
      failures++;
      $display("FAIL pt_second got v=%0b chan=%0d data=%0d exp v=1 chan=4 data=-5",
               bus.data_valid_out, bus.chan_out, bus.data_out);
    end
    checks++;
    if (bus.overflow_out !== 1'b0) begin
      failures++;
      $display("FAIL pt_ovf got=%0b exp=0", bus.overflow_out);
    end
    step();
    checks++;
    if (bus.data_valid_out !== 1'b0) begin
      failures++;
      $display("FAIL pt_drained got=%0b exp=0", bus.data_valid_out);
    end
  endtask

  task automatic test_avg4();
    int vals[4] = '{10, 11, 12, 14};
    update(2);
    for (int i = 0; i < 4; i++) begin
      sample_ev(1, -1, vals[i], 0);
      if (i < 3) begin
        checks++;
        if (bus.data_valid_out !== 1'b0) begin
          failures++;
          $display("FAIL avg4_early%0d got=%0b exp=0", i, bus.data_valid_out);
        end
      end
    end
    checks++;
    if (bus.data_valid_out !== 1'b1 || bus.chan_out !== 1 || bus.data_out !== 11) begin
      failures++;
      $display("FAIL avg4_result got v=%0b chan=%0d data=%0d exp v=1 chan=1 data=11",
               bus.data_valid_out, bus.chan_out, bus.data_out);
    end
    step();
  endtask

  task automatic test_floor();
    int pairs[3][2] = '{'{-3, -2}, '{131071, 131071}, '{-131072, -131072}};
    int exp_v[3]    = '{-3, 131071, -131072};
    update(1);
    for (int p = 0; p < 3; p++) begin
      sample_ev(2, -1, pairs[p][0], 0);
      sample_ev(2, -1, pairs[p][1], 0);
      checks++;
      if (bus.data_valid_out !== 1'b1 || bus.chan_out !== 2 || bus.data_out !== exp_v[p]) begin
        failures++;
        $display("FAIL floor_case%0d got v=%0b chan=%0d data=%0d exp v=1 chan=2 data=%0d",
                 p, bus.data_valid_out, bus.chan_out, bus.data_out, exp_v[p]);
      end
      step();
    end
  endtask

  task automatic test_overflow();
    int exp_c[4] = '{0, 4, 1, 5};
    int exp_d[4] = '{11, -41, 21, -51};
    bus.ready_in = 1'b0;
    update(0);
    sample_ev(0, 4, 11, -41);
    sample_ev(1, 5, 21, -51);
    checks++;
    if (bus.overflow_out !== 1'b0) begin
      failures++;
      $display("FAIL ovf_full_early got=%0b exp=0", bus.overflow_out);
    end
    sample_ev(2, 6, 31, -61);
    checks++;
    if (bus.overflow_out !== 1'b1) begin
      failures++;
      $display("FAIL ovf_set got=%0b exp=1", bus.overflow_out);
    end
    bus.ready_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.data_valid_out !== 1'b1 || bus.chan_out !== exp_c[i] || bus.data_out !== exp_d[i]) begin
        failures++;
        $display("FAIL ovf_drain%0d got v=%0b chan=%0d data=%0d exp v=1 chan=%0d data=%0d",
                 i, bus.data_valid_out, bus.chan_out, bus.data_out, exp_c[i], exp_d[i]);
      end
      step();
    end
    checks++;
    if (bus.data_valid_out !== 1'b0 || bus.overflow_out !== 1'b1) begin
      failures++;
      $display("FAIL ovf_after_drain got v=%0b ovf=%0b exp v=0 ovf=1",
               bus.data_valid_out, bus.overflow_out);
    end
  endtask

  task automatic test_clamp();
    bus.ready_in = 1'b1;
    update(3);
    checks++;
    if (bus.overflow_out !== 1'b0) begin
      failures++;
      $display("FAIL clamp_ovf_clear got=%0b exp=0", bus.overflow_out);
    end
    for (int i = 0; i < 4; i++) sample_ev(0, -1, 500, 0);
    update(15);
    for (int i = 0; i < 16; i++) begin
      sample_ev(0, -1, i * 7 - 50, 0);
      if (i < 15 && bus.data_valid_out !== 1'b0) begin
        checks++;
        failures++;
        $display("FAIL clamp_early%0d got=%0b exp=0", i, bus.data_valid_out);
      end
    end
    checks++;
    if (bus.data_valid_out !== 1'b1 || bus.chan_out !== 0 || bus.data_out !== 2) begin
      failures++;
      $display("FAIL clamp_result got v=%0b chan=%0d data=%0d exp v=1 chan=0 data=2",
               bus.data_valid_out, bus.chan_out, bus.data_out);
    end
    step();
  endtask

  task automatic test_reset_mid();
    bus.ready_in = 1'b0;
    update(1);
    sample_ev(0, 4, 10, 20);
    sample_ev(0, 4, 30, 40);
    sample_ev(3, -1, 999, 0);
    checks++;
    if (bus.data_valid_out !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_pending got=%0b exp=1", bus.data_valid_out);
    end
    reset_in = 1'b1;
    step();
    reset_in = 1'b0;
    checks++;
    if (bus.data_valid_out !== 1'b0 || bus.overflow_out !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_cleared got v=%0b ovf=%0b exp v=0 ovf=0",
               bus.data_valid_out, bus.overflow_out);
    end
    bus.ready_in = 1'b1;
    sample_ev(3, -1, 77, 0);
    checks++;
    if (bus.data_valid_out !== 1'b1 || bus.chan_out !== 3 || bus.data_out !== 77) begin
      failures++;
      $display("FAIL rstmid_fresh got v=%0b chan=%0d data=%0d exp v=1 chan=3 data=77",
               bus.data_valid_out, bus.chan_out, bus.data_out);
    end
    step();
  endtask

  task automatic test_random();
    logic [N_CHAN-1:0] v;
    logic signed [W_IN-1:0] exp_d;
    logic [2:0] exp_c;
    for (int n = 0; n < 3000; n++) begin
      v = '0;
      if ($urandom_range(0, 1) == 1) v[$urandom_range(0, HALF - 1)] = 1'b1;
      if ($urandom_range(0, 1) == 1) v[$urandom_range(HALF, N_CHAN - 1)] = 1'b1;
      bus.data_valid_in = v;
      bus.data_a_in     = W_IN'($urandom);
      bus.data_b_in     = W_IN'($urandom);
      bus.ready_in      = ($urandom_range(0, 3) != 0);
      bus.update_in     = ($urandom_range(0, 99) < 2);
      bus.avg_log2_in   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 2));
      step();
      bus.update_in     = 1'b0;
      checks++;
      if (bus.data_valid_out !== (q.size() != 0)) begin
        failures++;
        $display("FAIL rnd_valid cyc=%0d got=%0b exp=%0b", n, bus.data_valid_out, q.size() != 0);
      end
      if (q.size() != 0) begin
        exp_d = W_IN'(q[0].data);
        exp_c = 3'(q[0].chan);
        checks++;
        if (bus.chan_out !== exp_c || bus.data_out !== exp_d) begin
          failures++;
          $display("FAIL rnd_head cyc=%0d got chan=%0d data=%0d exp chan=%0d data=%0d",
                   n, bus.chan_out, bus.data_out, exp_c, exp_d);
        end
      end
      checks++;
      if (bus.overflow_out !== ovf_m) begin
        failures++;
        $display("FAIL rnd_ovf cyc=%0d got=%0b exp=%0b", n, bus.overflow_out, ovf_m);
      end
    end
    bus.data_valid_in = '0;
  endtask

  initial begin
    reset_in          = 1'b1;
    bus.data_valid_in = '0;
    bus.data_a_in     = '0;
    bus.data_b_in     = '0;
    bus.avg_log2_in   = '0;
    bus.update_in     = 1'b0;
    bus.ready_in      = 1'b0;
    test_reset();
    test_passthrough();
    test_avg4();
    test_floor();
    test_overflow();
    test_clamp();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
